// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the programmable serial sequence detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        HIT  = 2'd2
    } state_t;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/seq_hist_reg.sv
// Serial history shift register with a fill counter saturating at MAX_LEN.
module seq_hist_reg #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               shift,
    input  logic               clear,
    input  logic               din,
    output logic [MAX_LEN-1:0] history,
    output logic [LEN_W-1:0]   fill
);

    // Clear outranks shift so a discarded bit never lands in fresh history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            history <= '0;
            fill    <= '0;
        end else if (clear) begin
            history <= '0;
            fill    <= '0;
        end else if (shift) begin
            history <= {history[MAX_LEN-2:0], din};
            if (fill != LEN_W'(MAX_LEN))
                fill <= fill + LEN_W'(1);
        end
    end

endmodule

// File: rtl/prog_seq_det.sv
// Programmable serial sequence detector: FSM, compare, config registers and match counter.
module prog_seq_det
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               din,
    input  logic               din_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               clr,
    output logic               op,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err
);

    state_t             state;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               overlap;

    logic [MAX_LEN-1:0] history;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   next_fill;
    logic [MAX_LEN:0]   window;
    logic [MAX_LEN:0]   mask;
    logic               legal;
    logic               shift;
    logic               match;
    logic               hist_clear;

    assign legal  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign shift  = din_valid && (state != IDLE) && !cfg_load && !clr;
    assign window = {history, din};
    assign next_fill = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);

    // Compare the post-shift window; only the low len bits take part.
    always_comb begin
        mask = '0;
        for (int i = 0; i <= MAX_LEN; i++)
            mask[i] = (i < int'(len));
    end

    assign match = shift && (next_fill >= len) &&
                   (((window ^ {1'b0, pattern}) & mask) == '0);

    // Non-overlap mode restarts the fill after each hit.
    assign hist_clear = cfg_load || clr || (match && !overlap);

    seq_hist_reg #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_hist (
        .clk     (clk),
        .rst_n   (rst_n),
        .shift   (shift),
        .clear   (hist_clear),
        .din     (din),
        .history (history),
        .fill    (fill)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op        <= 1'b0;
            match_cnt <= '0;
            cfg_err   <= 1'b0;
            pattern   <= '0;
            len       <= '0;
            overlap   <= 1'b0;
        end else if (cfg_load) begin
            op <= 1'b0;
            if (clr)
                match_cnt <= '0;
            if (legal) begin
                pattern <= cfg_pattern;
                len     <= cfg_len;
                overlap <= cfg_overlap;
                cfg_err <= 1'b0;
                state   <= HUNT;
            end else begin
                cfg_err <= 1'b1;
                state   <= IDLE;
            end
        end else if (clr) begin
            op        <= 1'b0;
            match_cnt <= '0;
            state     <= (state == IDLE) ? IDLE : HUNT;
        end else if (state == IDLE) begin
            op <= 1'b0;
        end else if (match) begin
            state <= HIT;
            op    <= 1'b1;
            if (match_cnt != '1)
                match_cnt <= match_cnt + CNT_W'(1);
        end else begin
            state <= HUNT;
            op    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prog_seq_det.sv
// Scoreboard bench for prog_seq_det; a second instance with CNT_W=2 covers counter saturation.
module tb_prog_seq_det;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               din = 1'b0;
    logic               din_valid = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               clr = 1'b0;

    logic               op_a, op_b, err_a, err_b;
    logic [7:0]         cnt_a;
    logic [1:0]         cnt_b;

    typedef struct {
        logic       op;
        logic [7:0] c8;
        logic [1:0] c2;
        logic       err;
    } exp_t;

    exp_t sb[$];

    int check_count = 0;
    int pass_count  = 0;

    // Reference model state: received bits are kept oldest-first
    bit         configured;
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ov;
    bit         hist[$];
    int         m_c8;
    int         m_c2;
    bit         m_err;

    always #5 clk = ~clk;

    prog_seq_det dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .clr         (clr),
        .op          (op_a),
        .match_cnt   (cnt_a),
        .cfg_err     (err_a)
    );

    prog_seq_det #(.CNT_W(2)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .clr         (clr),
        .op          (op_b),
        .match_cnt   (cnt_b),
        .cfg_err     (err_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp)
            pass_count++;
        else
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic modelReset();
        configured = 1'b0;
        m_pat      = '0;
        m_len      = 0;
        m_ov       = 1'b0;
        hist.delete();
        m_c8       = 0;
        m_c2       = 0;
        m_err      = 1'b0;
    endtask

    // One clock of stimulus: drive, predict into the scoreboard, then pop and compare after the edge
    task automatic applyStimulus(input logic v, input logic d, input logic ld,
                                 input logic [7:0] pat, input logic [3:0] len,
                                 input logic ov, input logic c, input string tag);
        exp_t e;
        bit   hit;
        @(negedge clk);
        din_valid   = v;
        din         = d;
        cfg_load    = ld;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        clr         = c;

        e.op = 1'b0;
        if (ld) begin
            hist.delete();
            if (c) begin
                m_c8 = 0;
                m_c2 = 0;
            end
            if (len != 0 && len <= MAX_LEN) begin
                configured = 1'b1;
                m_pat = pat;
                m_len = len;
                m_ov  = ov;
                m_err = 1'b0;
            end else begin
                configured = 1'b0;
                m_err = 1'b1;
            end
        end else if (c) begin
            hist.delete();
            m_c8 = 0;
            m_c2 = 0;
        end else if (configured && v) begin
            hist.push_back(d);
            if (hist.size() > MAX_LEN)
                void'(hist.pop_front());
            hit = (hist.size() >= m_len);
            for (int i = 0; i < m_len; i++)
                if (hit && hist[hist.size() - 1 - i] != m_pat[i])
                    hit = 1'b0;
            if (hit) begin
                e.op = 1'b1;
                if (m_c8 < 255) m_c8++;
                if (m_c2 < 3)   m_c2++;
                if (!m_ov) hist.delete();
            end
        end
        e.c8  = 8'(m_c8);
        e.c2  = 2'(m_c2);
        e.err = m_err;
        sb.push_back(e);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        checkOutput({tag, ".op"},   32'(op_a),  32'(e.op));
        checkOutput({tag, ".op2"},  32'(op_b),  32'(e.op));
        checkOutput({tag, ".cnt"},  32'(cnt_a), 32'(e.c8));
        checkOutput({tag, ".cnt2"}, 32'(cnt_b), 32'(e.c2));
        checkOutput({tag, ".err"},  32'(err_a), 32'(e.err));
    endtask

    task automatic sendBit(input logic d, input string tag);
        applyStimulus(1'b1, d, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, tag);
    endtask

    task automatic gapCycle(input string tag);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, tag);
    endtask

    task automatic loadCfg(input logic [7:0] pat, input logic [3:0] len, input logic ov, input string tag);
        applyStimulus(1'b0, 1'b0, 1'b1, pat, len, ov, 1'b0, tag);
    endtask

    task automatic sendBits(input logic [15:0] bits, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--)
            sendBit(bits[i], tag);
    endtask

    task automatic midCycleReset(input string tag);
        @(negedge clk);
        din_valid = 1'b0;
        cfg_load  = 1'b0;
        clr       = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput({tag, ".op"},   32'(op_a),  32'(0));
        checkOutput({tag, ".cnt"},  32'(cnt_a), 32'(0));
        checkOutput({tag, ".cnt2"}, 32'(cnt_b), 32'(0));
        checkOutput({tag, ".err"},  32'(err_a), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        modelReset();
        #12;
        checkOutput("por.op",  32'(op_a),  32'(0));
        checkOutput("por.cnt", 32'(cnt_a), 32'(0));
        checkOutput("por.err", 32'(err_a), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Unconfigured: no detection
        sendBits(16'b101, 3, "noload");

        // 101 overlapping, then non-overlapping
        loadCfg(8'b101, 4'd3, 1'b1, "ld101ov");
        sendBits(16'b101010, 6, "ov101");
        loadCfg(8'b101, 4'd3, 1'b0, "ld101nov");
        sendBits(16'b101010, 6, "nov101");

        // 11 overlapping: run of ones, then gaps mid-stream
        loadCfg(8'b11, 4'd2, 1'b1, "ld11");
        sendBits(16'b1111, 4, "run11");
        gapCycle("gap0");
        sendBit(1'b0, "gapz");
        sendBit(1'b1, "gap1");
        gapCycle("gap2");
        gapCycle("gap3");
        sendBit(1'b1, "gap4");
        gapCycle("gap5");

        // Illegal loads, then a legal reload mid-stream that also carries a discarded bit
        loadCfg(8'b101, 4'd0, 1'b1, "len0");
        sendBits(16'b11, 2, "err");
        loadCfg(8'b101, 4'd9, 1'b1, "len9");
        sendBit(1'b1, "err9");
        loadCfg(8'b101, 4'd3, 1'b1, "ldok");
        sendBits(16'b10, 2, "pre");
        applyStimulus(1'b1, 1'b1, 1'b1, 8'b101, 4'd3, 1'b1, 1'b0, "ldmid");
        sendBits(16'b101, 3, "post");

        // Full-length pattern, non-overlapping
        loadCfg(8'b1011_0011, 4'd8, 1'b0, "ld8");
        sendBits(16'b1_1011_0011, 9, "len8");

        // Saturation, clr retains configuration, clr+load clears count
        loadCfg(8'b1, 4'd1, 1'b1, "ld1");
        sendBits(16'b1111111, 7, "sat");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, "clr");
        sendBits(16'b101, 3, "afterclr");
        applyStimulus(1'b1, 1'b1, 1'b1, 8'b11, 4'd2, 1'b0, 1'b1, "clrld");
        sendBits(16'b111, 3, "clrld11");

        // Reset mid-sequence: history discarded, detection requires a reload
        loadCfg(8'b101, 4'd3, 1'b1, "ldrst");
        sendBits(16'b1010, 4, "prerst");
        midCycleReset("rstmid");
        sendBits(16'b101, 3, "postrst");

        // Randomised configurations and streams with valid gaps
        for (int r = 0; r < 6; r++) begin
            loadCfg(8'($urandom), 4'($urandom_range(1, MAX_LEN)), 1'($urandom), "rndld");
            for (int k = 0; k < 30; k++)
                applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'b0,
                              8'h00, 4'd0, 1'b0, 1'b0, "rnd");
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
